obc_da_dft_bin: RTL
===================

OBC_DA_DFT_BIN -- requirements
Module: obc_da_dft_bin

Interface
REQ-001 Parameters: N_PTS, default 16, samples per frame (power of 2, >=4); DW, default 16, sample width (two's complement); CW, default 16, coefficient width (two's complement); AW, default DW+CW+$clog2(N_PTS), accumulator/output width.
REQ-002 Ports, one per line:
- clk, input, 1: the single clock; reset is asynchronous, active-low.
- rst_n, input, 1: asynchronous active-low reset.
- coef_we, input, 1: coefficient write strobe.
- coef_bank, input, 1: bank select; 0 = real (cos), 1 = imag (-sin).
- coef_addr, input, $clog2(N_PTS): sample index n.
- coef_data, input, CW: coefficient c[bank][n].
- s_valid, input, 1: sample beat valid.
- s_ready, output, 1: sample beat accepted.
- s_data, input, DW: sample x[n], n = 0..N_PTS-1 in beat order.
- m_valid, output, 1: result valid.
- m_ready, input, 1: result accepted.
- y_re, output, AW: sum of c[0][n]*x[n].
- y_im, output, AW: sum of c[1][n]*x[n].
- coef_err, output, 1: one-cycle pulse when a write is rejected.

Function
REQ-003 The FSM has 3 states: LOAD, COMPUTE, HOLD.
REQ-004 LOAD: s_ready=1; each s_valid&s_ready beat stores s_data into sample slot cnt, then cnt increments; the beat with cnt=N_PTS-1 wraps cnt to 0 and moves the FSM to COMPUTE.
REQ-005 COMPUTE runs exactly DW cycles, bit-plane b from DW-1 down to 0, MSB first; s_ready=0 during COMPUTE.
REQ-006 Per bank, each COMPUTE cycle: P_b = sum over n of (x[n][b] ? c[n] : 0), sign-extended to AW; acc <= (acc<<1) + (b==DW-1 ? -P_b : P_b); acc is cleared on entry to COMPUTE.
REQ-007 An all-zero bit-plane contributes P_b=0; no special case is permitted.
REQ-008 Results are exact modulo 2^AW; with default AW, overflow is impossible.
REQ-009 After the b=0 cycle, the next state is HOLD; y_re/y_im are registered; m_valid=1 exactly DW+1 cycles after the last sample beat.
REQ-010 HOLD: m_valid, y_re and y_im stay stable until m_valid&m_ready; then the FSM returns to LOAD in the next cycle. s_ready=0 in HOLD; there is no overlap of frames.
REQ-011 Coefficient writes are accepted in LOAD and HOLD.
REQ-012 A coef_we in COMPUTE is ignored and pulses coef_err for 1 cycle.
REQ-013 Coefficients persist across frames; they are not cleared by frame completion.
REQ-014 A coefficient write and a sample beat in the same LOAD cycle are both accepted; the new coefficient applies to the current frame.

Reset
REQ-015 On rst_n=0 (asynchronous), the following are reset:
- FSM to LOAD, cnt to 0.
- s_ready=0 while rst_n is low, then 1 from the first clock after release.
- m_valid=0, coef_err=0, y_re=0, y_im=0, acc=0.
- All coefficients and sample slots to 0.
REQ-016 Reset mid-COMPUTE or mid-HOLD discards the frame; no m_valid follows.

Structure
REQ-017 The package obc_da_pkg holds the state enum (LOAD/COMPUTE/HOLD) and the AW derivation function.
REQ-018 One sub-module, obc_da_plane_sum, is instantiated once per bank. It is combinational and computes P_b from the N_PTS bit-plane bits and the coefficients. The FSM, storage and accumulators stay in the top.

Verification
REQ-019 Bench scenarios (defaults):
- c_re[0]=1000, others 0; x[0]=1, others 0 -> y_re=1000, y_im=0, m_valid 17 cycles after the last beat.
- c_re[n]=1 for all n; x[n]=n -> y_re=120.
- c_im[0]=-32768; x[0]=-32768 -> y_im=2^30 (sign plane subtraction correct).
- Hold m_ready=0 for 5 cycles -> y_re stable, s_ready=0, no new frame accepted; then handshake -> s_ready=1 next cycle.
- coef_we during COMPUTE -> coef_err pulse, result unchanged; coef_we in HOLD -> the next frame uses the new value.
- Assert rst_n at COMPUTE cycle 8 -> all outputs 0 and no m_valid; the next full frame produces the correct result.

Source files
------------

// File: rtl/obc_da_pkg.sv
// Shared definitions for the distributed-arithmetic single-bin DFT.
//   state_t    : frame FSM states (LOAD -> COMPUTE -> HOLD -> LOAD)
//   obc_da_aw  : accumulator/output width that makes the dot product exact
package obc_da_pkg;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Full product width plus one bit per doubling of the term count.
  function automatic int obc_da_aw(input int dw, input int cw, input int n_pts);
    return dw + cw + $clog2(n_pts);
  endfunction

endpackage

// File: rtl/obc_da_plane_sum.sv
// Combinational bit-plane partial sum for one coefficient bank.
//   bits : bit b of every stored sample, one bit per sample slot
//   coef : coefficient per sample slot (two's complement)
//   psum : sum of coef[n] over slots whose bit is set, sign-extended to AW
module obc_da_plane_sum #(
  parameter int N_PTS = 16,
  parameter int CW    = 16,
  parameter int AW    = 36
) (
  input  logic [N_PTS-1:0]       bits,
  input  logic signed [CW-1:0]   coef [N_PTS],
  output logic signed [AW-1:0]   psum
);

  always_comb begin
    psum = '0;
    for (int n = 0; n < N_PTS; n++) begin
      if (bits[n]) psum = psum + AW'(coef[n]);
    end
  end

endmodule

// File: rtl/obc_da_dft_bin.sv
// Single-bin DFT by bit-serial distributed arithmetic.
// A frame of N_PTS samples is loaded, then DW bit-plane cycles (MSB first)
// accumulate sum(c_re[n]*x[n]) and sum(c_im[n]*x[n]); the result is held
// until the consumer accepts it.
//   clk, rst_n                : clock, asynchronous active-low reset
//   coef_we/bank/addr/data    : coefficient write port (rejected in COMPUTE)
//   s_valid/s_ready/s_data    : sample input stream
//   m_valid/m_ready/y_re/y_im : result output
//   coef_err                  : one-cycle pulse for a rejected coefficient write
module obc_da_dft_bin
  import obc_da_pkg::*;
#(
  parameter int N_PTS = 16,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int AW    = obc_da_aw(DW, CW, N_PTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      coef_we,
  input  logic                      coef_bank,
  input  logic [$clog2(N_PTS)-1:0]  coef_addr,
  input  logic signed [CW-1:0]      coef_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic signed [DW-1:0]      s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic signed [AW-1:0]      y_re,
  output logic signed [AW-1:0]      y_im,
  output logic                      coef_err
);

  localparam int NW = $clog2(N_PTS);
  localparam int BW = $clog2(DW);
  localparam logic [NW-1:0] CNT_LAST = NW'(N_PTS - 1);
  localparam logic [BW-1:0] BIT_TOP  = BW'(DW - 1);

  state_t                state, state_nxt;
  logic [NW-1:0]         cnt;
  logic [BW-1:0]         bit_idx;
  logic signed [DW-1:0]  x_p0 [N_PTS];
  logic signed [CW-1:0]  c_re [N_PTS];
  logic signed [CW-1:0]  c_im [N_PTS];
  logic [N_PTS-1:0]      plane;
  logic signed [AW-1:0]  p_re, p_im;
  logic signed [AW-1:0]  acc_re_p1, acc_im_p1, acc_re_nxt, acc_im_nxt;
  logic signed [AW-1:0]  y_re_p2, y_im_p2;
  logic                  vld_p2;
  logic                  beat, frame_done, last_plane, coef_ok;

  // The sign plane carries weight -2^(DW-1), so its partial sum is subtracted.
  function automatic logic signed [AW-1:0] plane_term(input logic signed [AW-1:0] p,
                                                      input logic sign_plane);
    return sign_plane ? -p : p;
  endfunction

  assign beat       = s_valid && s_ready;
  assign frame_done = beat && (cnt == CNT_LAST);
  assign last_plane = (state == COMPUTE) && (bit_idx == '0);
  assign coef_ok    = coef_we && (state != COMPUTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (frame_done)        state_nxt = COMPUTE;
      COMPUTE: if (bit_idx == '0)     state_nxt = HOLD;
      HOLD:    if (vld_p2 && m_ready) state_nxt = LOAD;
      default:                        state_nxt = LOAD;
    endcase
  end

  // s_ready is registered from the next state so it stays low during reset
  // and rises on the first clock after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_idx  <= '0;
      s_ready  <= 1'b0;
      vld_p2   <= 1'b0;
      coef_err <= 1'b0;
    end else begin
      s_ready  <= (state_nxt == LOAD);
      coef_err <= coef_we && (state == COMPUTE);
      if (beat) cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (frame_done)              bit_idx <= BIT_TOP;
      else if (state == COMPUTE)   bit_idx <= bit_idx - 1'b1;
      if (last_plane)              vld_p2 <= 1'b1;
      else if (vld_p2 && m_ready)  vld_p2 <= 1'b0;
    end
  end

  // ---- stage p0: sample and coefficient storage ----
  always_comb begin
    plane = '0;
    for (int n = 0; n < N_PTS; n++) plane[n] = x_p0[n][bit_idx];
  end

  obc_da_plane_sum #(.N_PTS(N_PTS), .CW(CW), .AW(AW)) u_sum_re (
    .bits (plane),
    .coef (c_re),
    .psum (p_re)
  );

  obc_da_plane_sum #(.N_PTS(N_PTS), .CW(CW), .AW(AW)) u_sum_im (
    .bits (plane),
    .coef (c_im),
    .psum (p_im)
  );

  // ---- stage p1: bit-serial accumulation, MSB plane first ----
  always_comb begin
    acc_re_nxt = (acc_re_p1 <<< 1) + plane_term(p_re, bit_idx == BIT_TOP);
    acc_im_nxt = (acc_im_p1 <<< 1) + plane_term(p_im, bit_idx == BIT_TOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < N_PTS; n++) begin
        x_p0[n] <= '0;
        c_re[n] <= '0;
        c_im[n] <= '0;
      end
      acc_re_p1 <= '0;
      acc_im_p1 <= '0;
      y_re_p2   <= '0;
      y_im_p2   <= '0;
    end else begin
      if (beat) x_p0[cnt] <= s_data;
      if (coef_ok) begin
        if (coef_bank) c_im[coef_addr] <= coef_data;
        else           c_re[coef_addr] <= coef_data;
      end
      if (frame_done) begin
        acc_re_p1 <= '0;
        acc_im_p1 <= '0;
      end else if (state == COMPUTE) begin
        acc_re_p1 <= acc_re_nxt;
        acc_im_p1 <= acc_im_nxt;
      end
      // ---- stage p2: result register held through HOLD ----
      if (last_plane) begin
        y_re_p2 <= acc_re_nxt;
        y_im_p2 <= acc_im_nxt;
      end
    end
  end

  assign m_valid = vld_p2;
  assign y_re    = y_re_p2;
  assign y_im    = y_im_p2;

endmodule
